fetch_decode: RTL and testbench

//  Instruction fetch/decode stage placed directly upstream of the CPU execute/ALU stage.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_decode.sv | 118 +++++++++++
 tb/tb_fetch_decode.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcodes, ALU selects
// and the fetch/decode state encoding.
package cpu_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 6;

  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_MUL = 2'b10;
  localparam logic [1:0] ALU_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_OP,
    S_A,
    S_B,
    S_PH,
    S_PL,
    S_IND,
    S_ISSUE,
    S_HALT
  } fd_state_e;

endpackage

// File: rtl/fetch_decode.sv
// Nibble fetch/decode stage feeding the execute/ALU stage.
// Ports: clk, rst_n (sync, low), mem_req/gnt/addr/rdata
// read port, out_valid/ready handshake with out_op/mem/a/b,
// pc, illegal_op pulse, sticky halted.
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_op,
  output logic              out_mem,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [ADDR_W-1:0] pc,
  output logic              illegal_op,
  output logic              halted
);

  fd_state_e         state_q;
  logic [DATA_W-1:0] ph_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              fire;
  logic [ADDR_W-1:0] pc_inc;

  assign fire   = mem_req & mem_gnt;
  assign pc_inc = pc + ADDR_W'(1);

  assign mem_addr = (state_q == S_IND) ? ptr_q : pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_OP;
      pc         <= RESET_PC;
      mem_req    <= 1'b0;
      out_valid  <= 1'b0;
      out_op     <= '0;
      out_mem    <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      illegal_op <= 1'b0;
      halted     <= 1'b0;
      ph_q       <= '0;
      ptr_q      <= '0;
    end else begin
      illegal_op <= 1'b0;
      unique case (state_q)
        S_OP: begin
          // req is low only in the first cycle out of reset
          mem_req <= 1'b1;
          if (fire) begin
            pc <= pc_inc;
            if (mem_rdata[3:0] == OPC_HALT) begin
              halted  <= 1'b1;
              mem_req <= 1'b0;
              state_q <= S_HALT;
            end else if (mem_rdata[3]) begin
              illegal_op <= 1'b1;
            end else begin
              out_op  <= mem_rdata[2:1];
              out_mem <= mem_rdata[0];
              state_q <= S_A;
            end
          end
        end
        S_A: if (fire) begin
          out_a   <= mem_rdata;
          pc      <= pc_inc;
          state_q <= out_mem ? S_PH : S_B;
        end
        S_B: if (fire) begin
          out_b     <= mem_rdata;
          pc        <= pc_inc;
          mem_req   <= 1'b0;
          out_valid <= 1'b1;
          state_q   <= S_ISSUE;
        end
        S_PH: if (fire) begin
          ph_q    <= mem_rdata;
          pc      <= pc_inc;
          state_q <= S_PL;
        end
        S_PL: if (fire) begin
          // truncation keeps PH[1:0] as the pointer's top bits
          ptr_q   <= ADDR_W'({ph_q, mem_rdata});
          pc      <= pc_inc;
          state_q <= S_IND;
        end
        S_IND: if (fire) begin
          out_b     <= mem_rdata;
          mem_req   <= 1'b0;
          out_valid <= 1'b1;
          state_q   <= S_ISSUE;
        end
        S_ISSUE: if (out_ready) begin
          out_valid <= 1'b0;
          mem_req   <= 1'b1;
          state_q   <= S_OP;
        end
        S_HALT: begin
          mem_req   <= 1'b0;
          out_valid <= 1'b0;
        end
        default: state_q <= S_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: scoreboard of
// issued instructions plus per-scenario inline checks.
module tb_fetch_decode;
  import cpu_pkg::*;

  typedef struct packed {
    logic [1:0] op;
    logic       m;
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] mem [64];

  logic       rst_n, gnt, ready;
  logic       mem_req, out_valid, out_mem, illegal_op, halted;
  logic [5:0] mem_addr, pc;
  logic [3:0] rdata, out_a, out_b;
  logic [1:0] out_op;

  logic       rst62, gnt62, ready62;
  logic       req62, valid62, mem62, ill62, halt62;
  logic [5:0] addr62, pc62;
  logic [3:0] rdata62, a62, b62;
  logic [1:0] op62;

  assign rdata   = mem[mem_addr];
  assign rdata62 = mem[addr62];

  fetch_decode dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_gnt(gnt),
    .mem_addr(mem_addr), .mem_rdata(rdata),
    .out_valid(out_valid), .out_ready(ready),
    .out_op(out_op), .out_mem(out_mem),
    .out_a(out_a), .out_b(out_b), .pc(pc),
    .illegal_op(illegal_op), .halted(halted)
  );

  fetch_decode #(.RESET_PC(6'd62)) dut62 (
    .clk(clk), .rst_n(rst62),
    .mem_req(req62), .mem_gnt(gnt62),
    .mem_addr(addr62), .mem_rdata(rdata62),
    .out_valid(valid62), .out_ready(ready62),
    .out_op(op62), .out_mem(mem62),
    .out_a(a62), .out_b(b62), .pc(pc62),
    .illegal_op(ill62), .halted(halt62)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n && out_valid && ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got op=%0d m=%0d a=%h b=%h, want none",
                 out_op, out_mem, out_a, out_b);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({out_op, out_mem, out_a, out_b} !== e) begin
          bad++;
          $display("FAIL sb_issue: got op=%0d m=%0d a=%h b=%h, want op=%0d m=%0d a=%h b=%h",
                   out_op, out_mem, out_a, out_b, e.op, e.m, e.a, e.b);
        end
      end
    end
  end

  // Counts negedges until out_valid; also returns mem_addr
  // seen in the cycle before valid.
  task automatic wait_valid(output int c, output logic [5:0] last);
    c = 0;
    last = '0;
    while (c < 30) begin
      @(negedge clk);
      c++;
      if (out_valid) return;
      last = mem_addr;
    end
    total++;
    bad++;
    $display("FAIL valid_timeout: got no valid, want valid within 30");
  endtask

  task automatic test_reset;
    rst_n = 1'b0; gnt = 1'b1; ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({mem_req, out_valid, pc, out_op, out_mem, out_a, out_b, illegal_op, halted}
        !== '0) begin
      bad++;
      $display("FAIL reset: got req=%b v=%b pc=%0d op=%0d m=%b a=%h b=%h ill=%b h=%b, want all 0",
               mem_req, out_valid, pc, out_op, out_mem, out_a, out_b, illegal_op, halted);
    end
  endtask

  task automatic test_reg_op;
    int c;
    logic [5:0] last;
    sb.push_back('{op: ALU_ADD, m: 1'b0, a: 4'd3, b: 4'd5});
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    wait_valid(c, last);
    total++;
    if (c != 4 || pc !== 6'd3) begin
      bad++;
      $display("FAIL reg_latency: got cycle=%0d pc=%0d, want cycle=4 pc=3", c, pc);
    end
  endtask

  task automatic test_mem_op;
    int c;
    logic [5:0] last;
    sb.push_back('{op: ALU_SUB, m: 1'b1, a: 4'd9, b: 4'd7});
    wait_valid(c, last);
    total++;
    if (c != 6 || pc !== 6'd7 || last !== 6'h2A) begin
      bad++;
      $display("FAIL mem_op: got cycle=%0d pc=%0d ind_addr=%h, want cycle=6 pc=7 ind_addr=2a",
               c, pc, last);
    end
  endtask

  task automatic test_gnt_stall;
    int c;
    logic [5:0] last;
    sb.push_back('{op: ALU_SUB, m: 1'b0, a: 4'd4, b: 4'd1});
    @(posedge clk); #1;
    @(posedge clk); #1 gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (pc !== 6'd8 || mem_addr !== 6'd8 || mem_req !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold: got pc=%0d addr=%0d req=%b, want pc=8 addr=8 req=1",
                 pc, mem_addr, mem_req);
      end
      @(posedge clk); #1;
    end
    gnt = 1'b1;
    wait_valid(c, last);
    total++;
    if (c != 3 || pc !== 6'd10) begin
      bad++;
      $display("FAIL stall_latency: got cycle=%0d pc=%0d, want cycle=3 pc=10", c, pc);
    end
  endtask

  task automatic test_ready_hold;
    int c;
    logic [5:0] last;
    sb.push_back('{op: ALU_DIV, m: 1'b0, a: 4'd7, b: 4'd3});
    @(posedge clk); #1 ready = 1'b0;
    wait_valid(c, last);
    total++;
    if (c != 4) begin
      bad++;
      $display("FAIL ready_latency: got cycle=%0d, want 4", c);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if ({out_valid, out_op, out_mem, out_a, out_b} !== {1'b1, ALU_DIV, 1'b0, 4'd7, 4'd3}) begin
        bad++;
        $display("FAIL ready_hold: got v=%b op=%0d m=%b a=%h b=%h, want v=1 op=3 m=0 a=7 b=3",
                 out_valid, out_op, out_mem, out_a, out_b);
      end
    end
    @(posedge clk); #1 ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL ready_accept: got v=%b pending=%0d, want v=0 pending=0",
               out_valid, sb.size());
    end
  endtask

  task automatic test_wrap;
    int c;
    mem[62] = 4'h4; mem[63] = 4'h2; mem[0] = 4'h6;
    gnt62 = 1'b1; ready62 = 1'b1;
    @(posedge clk); #1 rst62 = 1'b1;
    @(posedge clk);
    c = 0;
    while (c < 30) begin
      @(negedge clk);
      c++;
      if (valid62) break;
    end
    total++;
    if (c != 4 || {op62, mem62, a62, b62} !== {ALU_MUL, 1'b0, 4'd2, 4'd6} || pc62 !== 6'd1) begin
      bad++;
      $display("FAIL wrap: got cycle=%0d op=%0d m=%b a=%h b=%h pc=%0d, want cycle=4 op=2 m=0 a=2 b=6 pc=1",
               c, op62, mem62, a62, b62, pc62);
    end
    @(posedge clk); #1 rst62 = 1'b0;
  endtask

  task automatic test_illegal_halt;
    int pulses;
    pulses = 0;
    @(posedge clk); #1 rst_n = 1'b0;
    mem[0] = 4'h9; mem[1] = OPC_HALT;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (illegal_op) pulses++;
      if (i == 2) begin
        total++;
        if (illegal_op !== 1'b1 || pc !== 6'd1 || halted !== 1'b0) begin
          bad++;
          $display("FAIL illegal: got ill=%b pc=%0d h=%b, want ill=1 pc=1 h=0",
                   illegal_op, pc, halted);
        end
      end
      if (i >= 3) begin
        total++;
        if ({halted, mem_req, out_valid} !== 3'b100 || pc !== 6'd2) begin
          bad++;
          $display("FAIL halt: got h=%b req=%b v=%b pc=%0d, want h=1 req=0 v=0 pc=2",
                   halted, mem_req, out_valid, pc);
        end
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL illegal_pulse: got %0d pulses, want 1", pulses);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1 rst_n = 1'b0;
    mem[0] = 4'h4; mem[1] = 4'h2; mem[2] = 4'h6;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (out_op !== ALU_MUL || out_a !== 4'd2 || pc !== 6'd2) begin
      bad++;
      $display("FAIL mid_state: got op=%0d a=%h pc=%0d, want op=2 a=2 pc=2",
               out_op, out_a, pc);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_req, out_valid, pc, out_op, out_mem, out_a, out_b, illegal_op, halted}
        !== '0) begin
      bad++;
      $display("FAIL reset_mid: got req=%b v=%b pc=%0d op=%0d a=%h b=%h h=%b, want all 0",
               mem_req, out_valid, pc, out_op, out_a, out_b, halted);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 4'h0;
    mem[0] = 4'h0; mem[1] = 4'h3; mem[2] = 4'h5;
    mem[3] = 4'h3; mem[4] = 4'h9; mem[5] = 4'h2; mem[6] = 4'hA;
    mem[7] = 4'h2; mem[8] = 4'h4; mem[9] = 4'h1;
    mem[10] = 4'h6; mem[11] = 4'h7; mem[12] = 4'h3;
    mem[6'h2A] = 4'h7;
    rst62 = 1'b0; gnt62 = 1'b1; ready62 = 1'b1;
    test_reset();
    test_reg_op();
    test_mem_op();
    test_gnt_stall();
    test_ready_hold();
    test_wrap();
    test_illegal_halt();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
